regfile_write_ctrl: RTL and testbench

- Write-side controller for the 32 x 64-bit integer register file; complements the read-port 32:1 select tree.
- Accepts write-back requests over a valid/ready handshake and buffers up to 2 entries while the register file is held by `stall`.
- Decodes the 5-bit destination into a one-hot write-enable vector and presents one write per cycle in program order.
- Exports a pending-address mask so the hazard unit can detect RAW hazards on buffered writes.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_write_ctrl_decoder5_32.sv | 20 ++
 rtl/regfile_write_ctrl.sv | 168 ++++++++++++++++
 tb/tb_regfile_write_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the integer register-file write side.
//   Holds the register-file geometry, the write-buffer sizing and the
//   buffered write-entry type.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int NREGS    = 32;
    localparam int DATA_W   = 64;
    localparam int ZERO_REG = 31;

    // Write-buffer geometry. DEPTH must be a power of two so that the pointers
    // wrap naturally. CNT_W must be wide enough to hold the value DEPTH itself.
    localparam int DEPTH = 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_entry_t;

endpackage

// File: rtl/regfile_write_ctrl_decoder5_32.sv
// decoder5_32
//   Combinational address-to-one-hot decoder with enable. This is the inverse
//   of the read-side 32:1 select tree.
// Ports:
//   en_i      in   1       enable; all outputs are 0 when low
//   addr_i    in   ADDR_W  register index
//   onehot_o  out  NREGS   one-hot decode of addr_i, qualified by en_i
module decoder5_32
    import regfile_pkg::*;
(
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NREGS-1:0]  onehot_o
);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
        assign onehot_o[gi] = en_i && (addr_i == ADDR_W'(gi));
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl
//   Write-side controller for the 32 x 64-bit register file. It accepts
//   write-back requests over valid/ready and buffers up to DEPTH of them while
//   the register file is stalled. It issues one registered one-hot write per
//   cycle in acceptance order. It also exports a registered pending-address
//   mask, which the hazard unit uses to detect RAW hazards.
// Ports:
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous active-high reset
//   wr_valid      in   1       write-back request valid
//   wr_ready      out  1       buffer has room (request taken when valid&&ready)
//   wr_addr       in   ADDR_W  destination register
//   wr_data       in   DATA_W  write data
//   stall         in   1       register file unavailable; nothing issues
//   we_onehot     out  NREGS   registered one-hot write enable
//   wdata_out     out  DATA_W  registered write data qualified by we_onehot
//   pending_mask  out  NREGS   registers targeted by buffered or issuing writes
//   buf_count     out  2       occupied buffer entries
module regfile_write_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              stall,
    output logic [NREGS-1:0]  we_onehot,
    output logic [DATA_W-1:0] wdata_out,
    output logic [NREGS-1:0]  pending_mask,
    output logic [1:0]        buf_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_entry_t              buf_q [DEPTH];
    wr_entry_t              buf_d [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NREGS-1:0]       we_q, we_d;
    reg_data_t              wdata_q, wdata_d;
    logic [NREGS-1:0]       pend_q, pend_d;

    // ------------------------------------------------------------------
    // Handshake and control decisions
    // ------------------------------------------------------------------
    logic      accept;
    logic      push;
    logic      pop;
    logic      bypass;
    logic      enq;
    wr_entry_t head_entry;
    reg_addr_t issue_addr;
    logic      issue_en;

    assign wr_ready   = (count_q < CNT_W'(DEPTH));
    assign accept     = wr_valid && wr_ready;
    // XZR writes are consumed by the handshake but never reach the buffer.
    assign push       = accept && (wr_addr != ADDR_W'(ZERO_REG));
    assign pop        = !stall && (count_q != '0);
    // An empty, unstalled buffer forwards the request straight to the outputs.
    assign bypass     = push && (count_q == '0) && !stall;
    assign enq        = push && !bypass;
    assign head_entry = buf_q[head_q];

    // The buffer head takes priority. Bypass can only happen when the buffer
    // is empty, so the two sources never compete.
    assign issue_en   = pop || bypass;
    assign issue_addr = pop ? head_entry.addr : wr_addr;

    logic [NREGS-1:0] issue_onehot;

    decoder5_32 u_issue_dec (
        .en_i     (issue_en),
        .addr_i   (issue_addr),
        .onehot_o (issue_onehot)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = issue_onehot;
        wdata_d = wdata_q;

        if (pop) begin
            wdata_d = head_entry.data;
            head_d  = head_q + PTR_W'(1);
        end else if (bypass) begin
            wdata_d = wr_data;
        end

        if (enq) begin
            buf_d[tail_q] = '{addr: wr_addr, data: wr_data};
            tail_d        = tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end

    // ------------------------------------------------------------------
    // Pending mask: computed from the post-edge buffer contents, so that it
    // lines up with the registered we_onehot it is ORed with.
    // ------------------------------------------------------------------
    logic [NREGS-1:0] slot_mask [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi);
        logic [PTR_W-1:0] offset;
        logic             slot_valid;

        // A slot is occupied when its distance from the head is below the
        // count.
        assign offset     = SLOT - head_d;
        assign slot_valid = (CNT_W'(offset) < count_d);

        decoder5_32 u_pend_dec (
            .en_i     (slot_valid),
            .addr_i   (buf_d[gi].addr),
            .onehot_o (slot_mask[gi])
        );
    end

    always_comb begin
        pend_d = we_d;
        for (int i = 0; i < DEPTH; i++) begin
            pend_d = pend_d | slot_mask[i];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign we_onehot    = we_q;
    assign wdata_out    = wdata_q;
    assign pending_mask = pend_q;
    assign buf_count    = 2'(count_q);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl
//   Directed self-checking bench for regfile_write_ctrl. The inputs change #1
//   after a rising edge, and the outputs are sampled at the same point, so
//   each check observes the result of the edge that just occurred.
module tb_regfile_write_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        stall;
    logic [31:0] we_onehot;
    logic [63:0] wdata_out;
    logic [31:0] pending_mask;
    logic [1:0]  buf_count;

    int n_cmp = 0;
    int n_mis = 0;

    regfile_write_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .stall        (stall),
        .we_onehot    (we_onehot),
        .wdata_out    (wdata_out),
        .pending_mask (pending_mask),
        .buf_count    (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [4:0] a, input logic [63:0] d);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
    endtask

    // Checks the whole output set in one call.
    task automatic expect_all(input string tag, input logic [31:0] we, input logic [31:0] pm,
                              input logic [1:0] cnt, input logic rdy);
        check({tag, ".we"},    64'(we_onehot),    64'(we));
        check({tag, ".pend"},  64'(pending_mask), 64'(pm));
        check({tag, ".count"}, 64'(buf_count),    64'(cnt));
        check({tag, ".ready"}, 64'(wr_ready),     64'(rdy));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        req(1'b0, 5'd0, 64'd0);

        // Reset, then idle
        tick();
        tick();
        reset = 1'b0;
        expect_all("reset", 32'h0, 32'h0, 2'd0, 1'b1);
        check("reset.wdata", wdata_out, 64'h0);
        tick();
        expect_all("idle", 32'h0, 32'h0, 2'd0, 1'b1);

        // Bypass write: the request is visible one cycle after acceptance
        req(1'b1, 5'd5, 64'h0000_0000_0000_051D);
        tick();
        expect_all("bypass", 32'h0000_0020, 32'h0000_0020, 2'd0, 1'b1);
        check("bypass.wdata", wdata_out, 64'h51D);
        req(1'b0, 5'd0, 64'd0);
        tick();
        expect_all("bypass_after", 32'h0, 32'h0, 2'd0, 1'b1);
        check("bypass_after.wdata_hold", wdata_out, 64'h51D);

        // Stall and fill with two writes to register 3
        stall = 1'b1;
        req(1'b1, 5'd3, 64'd1);
        tick();
        expect_all("fill1", 32'h0, 32'h8, 2'd1, 1'b1);
        req(1'b1, 5'd3, 64'd2);
        tick();
        expect_all("fill2", 32'h0, 32'h8, 2'd2, 1'b0);
        req(1'b0, 5'd0, 64'd0);
        stall = 1'b0;
        tick();
        expect_all("drain1", 32'h8, 32'h8, 2'd1, 1'b1);
        check("drain1.wdata", wdata_out, 64'd1);
        tick();
        expect_all("drain2", 32'h8, 32'h8, 2'd0, 1'b1);
        check("drain2.wdata", wdata_out, 64'd2);
        tick();
        expect_all("drain_idle", 32'h0, 32'h0, 2'd0, 1'b1);

        // Zero register: accepted, but it never occupies the buffer or enables
        req(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        expect_all("xzr", 32'h0, 32'h0, 2'd0, 1'b1);
        check("xzr.wdata_hold", wdata_out, 64'd2);
        stall = 1'b1;
        req(1'b1, 5'd4, 64'h44);
        tick();
        req(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        expect_all("xzr_stalled", 32'h0, 32'h10, 2'd1, 1'b1);
        req(1'b0, 5'd0, 64'd0);
        stall = 1'b0;
        tick();
        expect_all("xzr_drain", 32'h10, 32'h10, 2'd0, 1'b1);
        check("xzr_drain.wdata", wdata_out, 64'h44);
        tick();
        check("xzr_quiet.we", 64'(we_onehot), 64'h0);

        // Simultaneous push and pop: 7 is buffered, 9 is pushed while 7 pops
        stall = 1'b1;
        req(1'b1, 5'd7, 64'h77);
        tick();
        expect_all("pp_hold7", 32'h0, 32'h80, 2'd1, 1'b1);
        stall = 1'b0;
        req(1'b1, 5'd9, 64'h99);
        tick();
        expect_all("pp_pop7", 32'h80, 32'h280, 2'd1, 1'b1);
        check("pp_pop7.wdata", wdata_out, 64'h77);
        req(1'b0, 5'd0, 64'd0);
        tick();
        expect_all("pp_pop9", 32'h200, 32'h200, 2'd0, 1'b1);
        check("pp_pop9.wdata", wdata_out, 64'h99);
        tick();

        // Full: a held request waits for the edge after a pop frees an entry
        stall = 1'b1;
        req(1'b1, 5'd4, 64'hA4);
        tick();
        req(1'b1, 5'd6, 64'hA6);
        tick();
        req(1'b1, 5'd10, 64'hAA);
        tick();
        expect_all("full_held", 32'h0, 32'h50, 2'd2, 1'b0);
        stall = 1'b0;
        tick();
        expect_all("full_pop4", 32'h10, 32'h50, 2'd1, 1'b1);
        check("full_pop4.wdata", wdata_out, 64'hA4);
        tick();
        expect_all("full_pop6", 32'h40, 32'h440, 2'd1, 1'b1);
        check("full_pop6.wdata", wdata_out, 64'hA6);
        req(1'b0, 5'd0, 64'd0);
        tick();
        expect_all("full_pop10", 32'h400, 32'h400, 2'd0, 1'b1);
        check("full_pop10.wdata", wdata_out, 64'hAA);
        tick();

        // Reset mid-operation discards the buffered writes
        stall = 1'b1;
        req(1'b1, 5'd1, 64'h11);
        tick();
        req(1'b1, 5'd2, 64'h22);
        tick();
        req(1'b0, 5'd0, 64'd0);
        check("midrst_pre.count", 64'(buf_count), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        expect_all("midrst", 32'h0, 32'h0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_all($sformatf("midrst_quiet%0d", i), 32'h0, 32'h0, 2'd0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
